// File: rtl/digit_scan_ctrl.sv
// rtl/digit_scan_ctrl.sv - 4-digit display scan controller with frame-synchronous data commit
module digit_scan_ctrl #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] digits_in,
    input  logic        load,
    output logic [1:0]  sel,
    output logic        sel_en,
    output logic [3:0]  digit_out,
    output logic        frame_done,
    output logic        load_pending
);

    typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;

    localparam logic [CNT_W-1:0] DW_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BL_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam bit               HAS_BLANK = (BLANK_CYCLES > 0);

    state_t           state, state_n;
    logic [1:0]       sel_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             slot_end;
    logic             boundary;
    logic [15:0]      active, shadow;

    always_comb begin
        state_n  = state;
        sel_n    = sel;
        cnt_n    = cnt;
        slot_end = 1'b0;
        if (!run) begin
            state_n = IDLE;
            sel_n   = 2'd0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = DWELL;
                    sel_n   = 2'd0;
                    cnt_n   = '0;
                end
                DWELL: begin
                    if (cnt == DW_LAST) begin
                        cnt_n = '0;
                        if (HAS_BLANK) state_n = BLANK;
                        else           slot_end = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt == BL_LAST) begin
                        cnt_n    = '0;
                        slot_end = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    sel_n   = 2'd0;
                    cnt_n   = '0;
                end
            endcase
            if (slot_end) begin
                state_n = DWELL;
                sel_n   = sel + 2'd1;
            end
        end
        boundary = slot_end && (sel == 2'd3);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= 2'd0;
            cnt        <= '0;
            sel_en     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            sel        <= sel_n;
            cnt        <= cnt_n;
            sel_en     <= (state_n == DWELL);
            frame_done <= boundary;
        end
    end

    // A load coinciding with the frame boundary bypasses the shadow entirely
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active       <= '0;
            shadow       <= '0;
            load_pending <= 1'b0;
        end else if (state == IDLE) begin
            if (load) begin
                active       <= digits_in;
                load_pending <= 1'b0;
            end
        end else if (boundary) begin
            if (load)              active <= digits_in;
            else if (load_pending) active <= shadow;
            load_pending <= 1'b0;
        end else if (load) begin
            shadow       <= digits_in;
            load_pending <= 1'b1;
        end
    end

    assign digit_out = active[4*sel +: 4];

endmodule
